pdp11_operand_fetch: RTL and testbench

//  Sequential operand-fetch unit for the PDP-11 core. Implements all eight addressing modes (0-7),

---
 rtl/pdp11_operand_fetch.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_pdp11_operand_fetch.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp11_operand_fetch.sv
// PDP-11 operand-fetch unit: resolves addressing modes 0-7 and fetches the operand over a req/ack read port.
// Build option: define ODD_ADDR_TRAP_EN to abort word reads from odd addresses with an err pulse.
module pdp11_operand_fetch #(
    parameter int DATA_W      = 16,
    parameter int SP_IDX      = 6,
    parameter int PC_IDX      = 7,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [2:0]        reg_sel,
    input  logic              byte_op,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] ea,
    output logic              ea_valid,
    output logic [2:0]        reg_rd_addr,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              reg_wr_en,
    output logic [2:0]        reg_wr_addr,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RDREG  = 3'd1;
    localparam logic [2:0] ST_IDXF   = 3'd2;
    localparam logic [2:0] ST_IDXADD = 3'd3;
    localparam logic [2:0] ST_PTRF   = 3'd4;
    localparam logic [2:0] ST_OPRF   = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;
    localparam logic [2:0] ST_ERR    = 3'd7;

    localparam logic [2:0] SP_SEL = 3'(SP_IDX);
    localparam logic [2:0] PC_SEL = 3'(PC_IDX);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = (ACK_TIMEOUT > 0) ? CNT_W'(ACK_TIMEOUT - 1) : '0;

`ifdef ODD_ADDR_TRAP_EN
    localparam bit ODD_TRAP = 1'b1;
`else
    localparam bit ODD_TRAP = 1'b0;
`endif

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);
    localparam logic [DATA_W-1:0] TWO = DATA_W'(2);

    logic [2:0]        state_q, state_d;
    logic [2:0]        mode_q, mode_d;
    logic [2:0]        sel_q, sel_d;
    logic              byte_q, byte_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic [DATA_W-1:0] ea_q, ea_d;
    logic              ea_valid_q, ea_valid_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic              mem_req_q, mem_req_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              wr_en_q, wr_en_d;
    logic [2:0]        wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic [DATA_W-1:0] r_val;
    logic [DATA_W-1:0] step;
    logic [DATA_W-1:0] idx_sum;
    logic [7:0]        byte_lane;
    logic              ack;
    logic              timed_out;
    logic              go;
    logic              go_word;
    logic [DATA_W-1:0] go_addr;
    logic [2:0]        go_state;
    logic              fail;
    logic              odd_trap;

    // Index and pointer modes need PC first; everything else reads the selected register.
    assign reg_rd_addr = (state_q == ST_RDREG && mode_q[2:1] == 2'b11) ? PC_SEL : sel_q;

    // A write issued last edge is still in flight to the file; forward it (PC update before IDXADD).
    assign r_val = (wr_en_q && wr_addr_q == reg_rd_addr) ? wr_data_q : reg_rd_data;

    assign step      = (byte_q && sel_q != SP_SEL && sel_q != PC_SEL) ? ONE : TWO;
    assign idx_sum   = r_val + x_q;
    assign byte_lane = ea_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
    assign ack       = mem_req_q && mem_ack;
    assign timed_out = (ACK_TIMEOUT > 0) && (wait_q == WAIT_LAST);

    assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
    assign done        = (state_q == ST_DONE);
    assign err         = (state_q == ST_ERR);
    assign operand     = operand_q;
    assign ea          = ea_q;
    assign ea_valid    = ea_valid_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

    // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        sel_d      = sel_q;
        byte_d     = byte_q;
        operand_d  = operand_q;
        ea_d       = ea_q;
        ea_valid_d = ea_valid_q;
        x_d        = x_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        wait_d     = wait_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        go         = 1'b0;
        go_word    = 1'b1;
        go_addr    = '0;
        go_state   = ST_OPRF;
        fail       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    sel_d   = reg_sel;
                    byte_d  = byte_op;
                    state_d = ST_RDREG;
                end
            end

            ST_RDREG: begin
                ea_valid_d = (mode_q != 3'd0);
                case (mode_q)
                    3'd0: begin
                        operand_d = byte_q ? {{(DATA_W-8){1'b0}}, r_val[7:0]} : r_val;
                        state_d   = ST_DONE;
                    end
                    3'd1: begin
                        ea_d    = r_val;
                        go      = 1'b1;
                        go_addr = r_val;
                        go_word = !byte_q;
                    end
                    3'd2: begin
                        ea_d      = r_val;
                        wr_en_d   = 1'b1;
                        wr_addr_d = sel_q;
                        wr_data_d = r_val + step;
                        go        = 1'b1;
                        go_addr   = r_val;
                        go_word   = !byte_q;
                    end
                    3'd3: begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = sel_q;
                        wr_data_d = r_val + TWO;
                        go        = 1'b1;
                        go_addr   = r_val;
                        go_state  = ST_PTRF;
                    end
                    3'd4: begin
                        ea_d      = r_val - step;
                        wr_en_d   = 1'b1;
                        wr_addr_d = sel_q;
                        wr_data_d = r_val - step;
                        go        = 1'b1;
                        go_addr   = r_val - step;
                        go_word   = !byte_q;
                    end
                    3'd5: begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = sel_q;
                        wr_data_d = r_val - TWO;
                        go        = 1'b1;
                        go_addr   = r_val - TWO;
                        go_state  = ST_PTRF;
                    end
                    default: begin
                        go       = 1'b1;
                        go_addr  = r_val;
                        go_state = ST_IDXF;
                    end
                endcase
            end

            ST_IDXF: begin
                if (ack) begin
                    x_d       = mem_rdata;
                    wr_en_d   = 1'b1;
                    wr_addr_d = PC_SEL;
                    wr_data_d = mem_addr_q + TWO;
                    mem_req_d = 1'b0;
                    state_d   = ST_IDXADD;
                end else if (timed_out) begin
                    fail = 1'b1;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end

            ST_IDXADD: begin
                go      = 1'b1;
                go_addr = idx_sum;
                if (mode_q[0]) begin
                    go_state = ST_PTRF;
                end else begin
                    ea_d    = idx_sum;
                    go_word = !byte_q;
                end
            end

            ST_PTRF: begin
                if (ack) begin
                    ea_d      = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = ST_OPRF;
                end else if (timed_out) begin
                    fail = 1'b1;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end

            ST_OPRF: begin
                // Entered from PTRF with the request dropped; the operand read is issued here.
                if (!mem_req_q) begin
                    go      = 1'b1;
                    go_addr = ea_q;
                    go_word = !byte_q;
                end else if (ack) begin
                    operand_d = byte_q ? {{(DATA_W-8){1'b0}}, byte_lane} : mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (timed_out) begin
                    fail = 1'b1;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        odd_trap = ODD_TRAP && go && go_word && go_addr[0];

        if (fail || odd_trap) begin
            state_d   = ST_ERR;
            mem_req_d = 1'b0;
        end else if (go) begin
            state_d    = go_state;
            mem_req_d  = 1'b1;
            mem_addr_d = go_addr;
            wait_d     = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= '0;
            sel_q      <= '0;
            byte_q     <= 1'b0;
            operand_q  <= '0;
            ea_q       <= '0;
            ea_valid_q <= 1'b0;
            x_q        <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            wait_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            sel_q      <= sel_d;
            byte_q     <= byte_d;
            operand_q  <= operand_d;
            ea_q       <= ea_d;
            ea_valid_q <= ea_valid_d;
            x_q        <= x_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            wait_q     <= wait_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_pdp11_operand_fetch.sv
// Self-checking bench for pdp11_operand_fetch: directed cases plus randomized ops against a behavioural model.
// Expectations follow the ODD_ADDR_TRAP_EN build option when it is defined.
module tb_pdp11_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mode;
    logic [2:0]  reg_sel;
    logic        byte_op;
    logic        busy, done, err;
    logic [15:0] operand, ea;
    logic        ea_valid;
    logic [2:0]  reg_rd_addr;
    logic [15:0] reg_rd_data;
    logic        reg_wr_en;
    logic [2:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

`ifdef ODD_ADDR_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic [15:0] rf       [8];
    logic [15:0] pre_vals [8];
    logic [15:0] m_rf     [8];
    logic [15:0] mem      [32768];
    logic        pre_load = 1'b0;
    logic        ack_en   = 1'b1;
    int          max_stall = 0;
    int          stall;
    int          req_cnt = 0;
    logic [15:0] last_addr = '0;
    int          n_pass = 0, n_fail = 0, n_total = 0;

    pdp11_operand_fetch dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .reg_sel(reg_sel), .byte_op(byte_op),
        .busy(busy), .done(done), .err(err), .operand(operand), .ea(ea), .ea_valid(ea_valid),
        .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Register file: combinational read, write on the rising edge.
    assign reg_rd_data = rf[reg_rd_addr];
    always @(posedge clk) begin
        if (pre_load) begin
            for (int i = 0; i < 8; i++) rf[i] <= pre_vals[i];
        end else if (reg_wr_en) begin
            rf[reg_wr_addr] <= reg_wr_data;
        end
    end

    always @(posedge clk) begin
        if (mem_req) begin
            req_cnt   <= req_cnt + 1;
            last_addr <= mem_addr;
        end
    end

    // Memory responder: random stall, one-cycle ack, aligned word returned.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        stall     = 0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                stall     = $urandom_range(0, max_stall);
            end else if (!mem_req) begin
                stall = $urandom_range(0, max_stall);
            end else if (ack_en) begin
                if (stall == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr[15:1]];
                end else begin
                    stall--;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rd(input logic [15:0] a);
        return mem[a[15:1]];
    endfunction

    function automatic logic [127:0] dut_rf();
        return {rf[7], rf[6], rf[5], rf[4], rf[3], rf[2], rf[1], rf[0]};
    endfunction

    function automatic logic [127:0] mdl_rf();
        return {m_rf[7], m_rf[6], m_rf[5], m_rf[4], m_rf[3], m_rf[2], m_rf[1], m_rf[0]};
    endfunction

    // Reference: PDP-11 addressing semantics on m_rf and mem.
    function automatic void model(input logic [2:0] m, input logic [2:0] r, input logic b,
                                  output logic [15:0] e_op, output logic [15:0] e_ea,
                                  output logic e_err);
        logic [15:0] st, rv, p, x, w;
        logic        ptr;
        st    = (b && r != 3'd6 && r != 3'd7) ? 16'd1 : 16'd2;
        rv    = m_rf[r];
        ptr   = 1'b0;
        p     = '0;
        e_op  = '0;
        e_ea  = '0;
        e_err = 1'b0;
        case (m)
            3'd0: begin e_op = b ? {8'h00, rv[7:0]} : rv; return; end
            3'd1: e_ea = rv;
            3'd2: begin e_ea = rv; m_rf[r] = rv + st; end
            3'd3: begin p = rv; m_rf[r] = rv + 16'd2; ptr = 1'b1; end
            3'd4: begin m_rf[r] = rv - st; e_ea = rv - st; end
            3'd5: begin m_rf[r] = rv - 16'd2; p = rv - 16'd2; ptr = 1'b1; end
            default: begin
                if (TRAP && m_rf[7][0]) begin e_err = 1'b1; return; end
                x = rd(m_rf[7]);
                m_rf[7] = m_rf[7] + 16'd2;
                if (m == 3'd6) e_ea = m_rf[r] + x;
                else begin p = m_rf[r] + x; ptr = 1'b1; end
            end
        endcase
        if (ptr) begin
            if (TRAP && p[0]) begin e_err = 1'b1; return; end
            e_ea = rd(p);
        end
        if (TRAP && !b && e_ea[0]) begin e_err = 1'b1; return; end
        w    = rd(e_ea);
        e_op = b ? (e_ea[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]}) : w;
    endfunction

    task automatic load_regs();
        @(negedge clk);
        pre_load = 1'b1;
        @(negedge clk);
        pre_load = 1'b0;
        for (int i = 0; i < 8; i++) m_rf[i] = pre_vals[i];
    endtask

    task automatic do_op(input logic [2:0] m, input logic [2:0] r, input logic b,
                         output int cycles, output int reqs);
        int req0;
        @(negedge clk);
        mode = m; reg_sel = r; byte_op = b; start = 1'b1;
        req0 = req_cnt;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        while (!done && !err && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        reqs = req_cnt - req0;
        if (cycles >= 400) check("op_completes", 1'b0, 1'b1);
    endtask

    initial begin
        int          cyc, rq;
        logic [15:0] e_op, e_ea;
        logic        e_err;
        logic [2:0]  rm, rr;
        logic        rb;

        reset = 1'b1; start = 1'b0; mode = '0; reg_sel = '0; byte_op = 1'b0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) pre_vals[i] = 16'(i * 16'h0100);
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {busy, done, err, mem_req, reg_wr_en, ea_valid, operand, ea, mem_addr}, '0);
        reset = 1'b0;

        // Mode 0 register operand
        pre_vals[3] = 16'h1234;
        load_regs();
        do_op(3'd0, 3'd3, 1'b0, cyc, rq);
        check("m0_latency", 32'(cyc), 32'd2);
        check("m0_done_busy", {done, busy, ea_valid}, 3'b100);
        check("m0_operand", operand, 16'h1234);
        check("m0_no_req", 32'(rq), 32'd0);

        // Mode 2 byte autoincrement, general register then SP
        mem[16'h1000 >> 1] = 16'hAB12;
        pre_vals[1] = 16'h1000;
        load_regs();
        do_op(3'd2, 3'd1, 1'b1, cyc, rq);
        check("m2_byte_r1", rf[1], 16'h1001);
        check("m2_byte_ea", {ea_valid, ea}, {1'b1, 16'h1000});
        check("m2_byte_operand", operand, 16'h0012);
        pre_vals[6] = 16'h1000;
        load_regs();
        do_op(3'd2, 3'd6, 1'b1, cyc, rq);
        check("m2_byte_sp", rf[6], 16'h1002);
        check("m2_byte_sp_operand", operand, 16'h0012);

        // Mode 4 word autodecrement wrapping below zero
        mem[16'hFFFE >> 1] = 16'h5555;
        pre_vals[2] = 16'h0000;
        load_regs();
        do_op(3'd4, 3'd2, 1'b0, cyc, rq);
        check("m4_wrap_r2", rf[2], 16'hFFFE);
        check("m4_wrap_ea", ea, 16'hFFFE);
        check("m4_wrap_operand", operand, 16'h5555);

        // Mode 7 index deferred through PC, without and with ack stalls
        mem[16'h0200 >> 1] = 16'h0010;
        mem[16'h0212 >> 1] = 16'h3000;
        mem[16'h3000 >> 1] = 16'hBEEF;
        for (int pass = 0; pass < 2; pass++) begin
            max_stall   = (pass == 0) ? 0 : 5;
            pre_vals[7] = 16'h0200;
            load_regs();
            do_op(3'd7, 3'd7, 1'b0, cyc, rq);
            check("m7_pc", rf[7], 16'h0202);
            check("m7_ea", ea, 16'h3000);
            check("m7_operand", {done, operand}, {1'b1, 16'hBEEF});
        end
        max_stall = 0;

        // Mode 1 word from odd address
        pre_vals[0] = 16'h1001;
        load_regs();
        do_op(3'd1, 3'd0, 1'b0, cyc, rq);
        if (TRAP) begin
            check("odd_trap_err", {err, done}, 2'b10);
            check("odd_trap_no_req", 32'(rq), 32'd0);
        end else begin
            check("odd_no_trap_done", {err, done}, 2'b01);
            check("odd_no_trap_addr", last_addr, 16'h1001);
            check("odd_no_trap_operand", operand, 16'hAB12);
        end

        // Ack timeout
        ack_en      = 1'b0;
        pre_vals[1] = 16'h2000;
        load_regs();
        do_op(3'd1, 3'd1, 1'b0, cyc, rq);
        check("timeout_err", {err, done, busy, mem_req}, 4'b1000);
        check("timeout_wait_cycles", 32'(rq), 32'd15);
        @(negedge clk);
        check("timeout_err_pulse", {err, mem_req}, 2'b00);

        // Reset while waiting in OPRF
        @(negedge clk);
        mode = 3'd1; reg_sel = 3'd1; byte_op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset_req", {busy, mem_req}, 2'b11);
        reset = 1'b1;
        @(negedge clk);
        check("mid_op_reset",
              {busy, done, err, mem_req, reg_wr_en, ea_valid, operand, ea, mem_addr}, '0);
        reset  = 1'b0;
        ack_en = 1'b1;

        // Randomized operations against the model
        max_stall = 3;
        for (int n = 0; n < 80; n++) begin
            for (int i = 0; i < 8; i++) pre_vals[i] = 16'($urandom);
            rm = 3'($urandom);
            rr = 3'($urandom);
            rb = (rm == 3'd0) ? 1'b0 : 1'($urandom);
            load_regs();
            model(rm, rr, rb, e_op, e_ea, e_err);
            do_op(rm, rr, rb, cyc, rq);
            check($sformatf("rand%0d_m%0d_r%0d_b%0d_status", n, rm, rr, rb), {err, done}, {e_err, !e_err});
            check($sformatf("rand%0d_regs", n), dut_rf(), mdl_rf());
            if (!e_err) begin
                check($sformatf("rand%0d_operand", n), operand, e_op);
                check($sformatf("rand%0d_ea_valid", n), ea_valid, rm != 3'd0);
                if (rm != 3'd0) check($sformatf("rand%0d_ea", n), ea, e_ea);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
